// File: rtl/dec_pkg.sv
// dec_pkg: definitions shared by the substream suffix-window blocks.
//   SUFFIX_W    - width of the window presented to the parse stage
//   MAX_CONSUME - largest legal bp_size per parse
//   dec_state_e - window fill state
//   state_from_fill - classifies a fill count into a fill state
package dec_pkg;

    localparam int SUFFIX_W    = 128;
    localparam int MAX_CONSUME = 128;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_ERR   = 2'd3
    } dec_state_e;

    // Classifies a (never negative) fill count into the non-error states.
    function automatic dec_state_e state_from_fill(input logic [9:0] fill);
        dec_state_e st;
        if (fill == 10'd0) begin
            st = S_EMPTY;
        end else if (fill < 10'(SUFFIX_W)) begin
            st = S_PRIME;
        end else begin
            st = S_RUN;
        end
        return st;
    endfunction

endpackage

// File: rtl/dec_bit_shifter.sv
// dec_bit_shifter: combinational left barrel shifter, zero fill from the LSB.
// Ports:
//   data_i  [BUF_W-1:0]  value to shift
//   shamt_i [7:0]        shift amount in bits
//   data_o  [BUF_W-1:0]  data_i << shamt_i
module dec_bit_shifter #(
    parameter int BUF_W = 256
) (
    input  logic [BUF_W-1:0] data_i,
    input  logic [7:0]       shamt_i,
    output logic [BUF_W-1:0] data_o
);

    // Pure left shift; vacated low bits become zero.
    always_comb begin
        data_o = data_i << shamt_i;
    end

endmodule

// File: rtl/dec_ssm_suffix_window.sv
// dec_ssm_suffix_window: per-substream bit funnel feeding the BP-mode BPV/ECG
// parser. 32-bit words are packed MSB-first into a 256-bit buffer; the top 128
// bits form the suffix window and the parser's consumed bit count is shifted
// out each cycle. Consume and append in the same cycle are both applied.
// Optional build macro: DEC_SUFFIX_BITCNT_EN adds the consumed_bits counter.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   slice_start            - discard all buffered bits and clear the error
//   in_valid/in_data/in_ready - word input from the substream FIFO
//   suffix/suffix_valid    - 128-bit window, suffix[127] = next bit
//   consume_valid/consume_size - bits consumed by the parser (0..128)
//   fill_level             - valid bits held in the buffer
//   err                    - sticky protocol error
//   consumed_bits          - (macro only) bits consumed since reset/slice start
module dec_ssm_suffix_window
    import dec_pkg::*;
#(
    parameter int ssm_idx = 0,
    parameter int WORD_W  = 32,
    parameter int BUF_W   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                slice_start,
    input  logic                in_valid,
    input  logic [WORD_W-1:0]   in_data,
    output logic                in_ready,
    output logic [SUFFIX_W-1:0] suffix,
    output logic                suffix_valid,
    input  logic                consume_valid,
    input  logic [7:0]          consume_size,
    output logic [8:0]          fill_level,
    output logic                err
`ifdef DEC_SUFFIX_BITCNT_EN
    ,
    output logic [31:0]         consumed_bits
`endif
);

    localparam logic [8:0] FILL_MAX_APPEND = 9'(BUF_W - WORD_W);

    // Illegal geometry leaves this marker block in the elaborated hierarchy.
    if ((BUF_W < SUFFIX_W + WORD_W) || ((BUF_W % WORD_W) != 0) || (ssm_idx < 0)) begin : g_bad_params
    end

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [8:0]       fill_q, fill_d;
    dec_state_e       state_q, state_d;
    logic             err_q, err_d;

    logic             in_ready_s;
    logic             suffix_valid_s;
    logic             proto_err_s;
    logic [7:0]       shamt_s;
    logic [BUF_W-1:0] shifted_s;
    logic [BUF_W-1:0] word_pos_s;
    logic [9:0]       fill_c_s;
    logic [9:0]       fill_n_s;

`ifdef DEC_SUFFIX_BITCNT_EN
    logic [31:0]      cnt_q, cnt_d;
`endif

    // Readiness depends only on registered fill/state; held low during reset.
    always_comb begin
        in_ready_s     = rst_n && (fill_q <= FILL_MAX_APPEND) && (state_q != S_ERR);
        suffix_valid_s = (state_q == S_RUN);
    end

    // A zero shift when no consume is presented keeps the buffer untouched.
    always_comb begin
        shamt_s = consume_valid ? consume_size : 8'd0;
    end

    dec_bit_shifter #(
        .BUF_W(BUF_W)
    ) u_shifter (
        .data_i (buf_q),
        .shamt_i(shamt_s),
        .data_o (shifted_s)
    );

    // Fill after the consume step, then the incoming word placed just below it.
    always_comb begin
        fill_c_s   = {1'b0, fill_q} - {2'b00, shamt_s};
        word_pos_s = {in_data, {(BUF_W-WORD_W){1'b0}}} >> fill_c_s[8:0];
        fill_n_s   = fill_c_s;
        if (in_valid && in_ready_s) begin
            fill_n_s = fill_c_s + 10'(WORD_W);
        end else begin
            fill_n_s = fill_c_s;
        end
    end

    // Next-state: slice start, then held error, then new error, then consume+append.
    always_comb begin
        buf_d       = buf_q;
        fill_d      = fill_q;
        state_d     = state_q;
        err_d       = err_q;
        proto_err_s = consume_valid && (!suffix_valid_s || (consume_size > 8'(MAX_CONSUME)));
`ifdef DEC_SUFFIX_BITCNT_EN
        cnt_d       = cnt_q;
`endif
        if (slice_start) begin
            buf_d   = '0;
            fill_d  = 9'd0;
            state_d = S_EMPTY;
            err_d   = 1'b0;
`ifdef DEC_SUFFIX_BITCNT_EN
            cnt_d   = 32'd0;
`endif
        end else if (state_q == S_ERR) begin
            err_d   = 1'b1;
        end else if (proto_err_s) begin
            err_d   = 1'b1;
            state_d = S_ERR;
        end else begin
            // Bits below the fill are always zero, so OR-ing the word in is safe.
            buf_d   = shifted_s | ((in_valid && in_ready_s) ? word_pos_s : {BUF_W{1'b0}});
            fill_d  = fill_n_s[8:0];
            state_d = state_from_fill(fill_n_s);
`ifdef DEC_SUFFIX_BITCNT_EN
            cnt_d   = cnt_q + {24'd0, shamt_s};
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q   <= '0;
            fill_q  <= 9'd0;
            state_q <= S_EMPTY;
            err_q   <= 1'b0;
`ifdef DEC_SUFFIX_BITCNT_EN
            cnt_q   <= 32'd0;
`endif
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            err_q   <= err_d;
`ifdef DEC_SUFFIX_BITCNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs are taken straight from registers (in_ready from registered fill/state).
    always_comb begin
        in_ready     = in_ready_s;
        suffix_valid = suffix_valid_s;
        suffix       = buf_q[BUF_W-1 -: SUFFIX_W];
        fill_level   = fill_q;
        err          = err_q;
`ifdef DEC_SUFFIX_BITCNT_EN
        consumed_bits = cnt_q;
`endif
    end

endmodule

// File: tb/tb_dec_ssm_suffix_window.sv
// Testbench for dec_ssm_suffix_window: bit-queue reference model feeding a
// scoreboard of expected outputs, a table of vectors with hand-derived fill
// and error values, and hand-written multi-cycle sequences.
module tb_dec_ssm_suffix_window;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         slice_start;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [127:0] suffix;
    logic         suffix_valid;
    logic         consume_valid;
    logic [7:0]   consume_size;
    logic [8:0]   fill_level;
    logic         err;
`ifdef DEC_SUFFIX_BITCNT_EN
    logic [31:0]  consumed_bits;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_ssm_suffix_window #(
        .ssm_idx(0),
        .WORD_W (32),
        .BUF_W  (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slice_start  (slice_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .suffix       (suffix),
        .suffix_valid (suffix_valid),
        .consume_valid(consume_valid),
        .consume_size (consume_size),
        .fill_level   (fill_level),
        .err          (err)
`ifdef DEC_SUFFIX_BITCNT_EN
        ,
        .consumed_bits(consumed_bits)
`endif
    );

    typedef struct {
        logic [127:0] suffix;
        logic [8:0]   fill;
        logic [2:0]   flags;   // {in_ready, suffix_valid, err}
        logic [31:0]  cnt;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        cv;
        logic [7:0]  cs;
        logic        ss;
        logic [8:0]  exp_fill;
        logic        exp_err;
    } vec_t;

    exp_t sb[$];
    bit   mq[$];          // model: unconsumed stream bits, front = next bit
    bit   m_err = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        int   n;
        n = mq.size();
        e.suffix = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < n) e.suffix[127-i] = mq[i];
        end
        e.fill  = 9'(n);
        e.flags = {(!m_err && n <= 224), (!m_err && n >= 128), m_err};
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'd0, 128'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_suffix"}, suffix, e.suffix);
            chk({tag, "_fill"}, {119'd0, fill_level}, {119'd0, e.fill});
            chk({tag, "_rdy_sv_err"}, {125'd0, in_ready, suffix_valid, err}, {125'd0, e.flags});
`ifdef DEC_SUFFIX_BITCNT_EN
            chk({tag, "_cnt"}, {96'd0, consumed_bits}, {96'd0, e.cnt});
`endif
        end
    endtask

    // One clock cycle: drive inputs, advance the model, push expectation, compare.
    task automatic step(input logic iv, input logic [31:0] d, input logic cv,
                        input logic [7:0] cs, input logic ss, input string tag);
        bit rdy, sv;
        in_valid      = iv;
        in_data       = d;
        consume_valid = cv;
        consume_size  = cs;
        slice_start   = ss;
        rdy = !m_err && (mq.size() <= 224);
        sv  = !m_err && (mq.size() >= 128);
        if (ss) begin
            mq.delete();
            m_err = 1'b0;
            m_cnt = 32'd0;
        end else if (!m_err) begin
            if (cv && (!sv || cs > 8'd128)) begin
                m_err = 1'b1;
            end else begin
                if (cv) begin
                    for (int i = 0; i < int'(cs); i++) void'(mq.pop_front());
                    m_cnt = m_cnt + {24'd0, cs};
                end
                if (iv && rdy) begin
                    for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
                end
            end
        end
        sb.push_back(model_outputs());
        @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    task automatic do_reset(input string tag);
        exp_t z;
        rst_n = 1'b0;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        consume_valid = 1'b0; consume_size = 8'd0; slice_start = 1'b0;
        mq.delete(); m_err = 1'b0; m_cnt = 32'd0;
        z.suffix = '0; z.fill = 9'd0; z.flags = 3'b000; z.cnt = 32'd0;
        sb.push_back(z);
        @(posedge clk);
        #1;
        check_sb(tag);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk({tag, "_rdy_after"}, {127'd0, in_ready}, 128'd1);
    endtask

    vec_t vecs[14];
    int   pos;
    logic [127:0] w;

    initial begin
        vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 8'd0,   1'b0, 9'd32,  1'b0};
        vecs[1]  = '{1'b1, 32'h01234567, 1'b0, 8'd0,   1'b0, 9'd64,  1'b0};
        vecs[2]  = '{1'b1, 32'h89ABCDEF, 1'b0, 8'd0,   1'b0, 9'd96,  1'b0};
        vecs[3]  = '{1'b1, 32'hFFFF0000, 1'b0, 8'd0,   1'b0, 9'd128, 1'b0};
        vecs[4]  = '{1'b1, 32'hAAAAAAAA, 1'b0, 8'd0,   1'b0, 9'd160, 1'b0};
        vecs[5]  = '{1'b1, 32'h55555555, 1'b0, 8'd0,   1'b0, 9'd192, 1'b0};
        vecs[6]  = '{1'b1, 32'h12345678, 1'b0, 8'd0,   1'b0, 9'd224, 1'b0};
        vecs[7]  = '{1'b1, 32'h9ABCDEF0, 1'b0, 8'd0,   1'b0, 9'd256, 1'b0};
        vecs[8]  = '{1'b1, 32'h00000000, 1'b0, 8'd0,   1'b0, 9'd256, 1'b0};
        vecs[9]  = '{1'b1, 32'h11111111, 1'b1, 8'd40,  1'b0, 9'd216, 1'b0};
        vecs[10] = '{1'b1, 32'hCAFEF00D, 1'b1, 8'd8,   1'b0, 9'd240, 1'b0};
        vecs[11] = '{1'b0, 32'h00000000, 1'b1, 8'd0,   1'b0, 9'd240, 1'b0};
        vecs[12] = '{1'b1, 32'h22222222, 1'b1, 8'd129, 1'b0, 9'd240, 1'b1};
        vecs[13] = '{1'b0, 32'h00000000, 1'b0, 8'd0,   1'b1, 9'd0,   1'b0};

        rst_n = 1'b0; slice_start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        consume_valid = 1'b0; consume_size = 8'd0;
        @(posedge clk);
        do_reset("rst");

        // Table: fill, saturate, consume, consume+append, no-op, oversize error, slice start.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].cv, vecs[i].cs, vecs[i].ss, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_fill_tbl", i), {119'd0, fill_level}, {119'd0, vecs[i].exp_fill});
            chk($sformatf("vec%0d_err_tbl", i), {127'd0, err}, {127'd0, vecs[i].exp_err});
            if (i == 3) begin
                w = 128'hDEADBEEF_01234567_89ABCDEF_FFFF0000;
                chk("first_window", suffix, w);
                chk("first_window_valid", {127'd0, suffix_valid}, 128'd1);
            end
        end
        chk("after_slice_rdy", {127'd0, in_ready}, 128'd1);

        // Alternating stream, 5 bits consumed per cycle while words keep arriving.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hAAAAAAAA, 1'b0, 8'd0, 1'b0, "alt_fill");
        pos = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'hAAAAAAAA, 1'b1, 8'd5, 1'b0, "alt_run");
            pos = pos + 5;
            w = (pos % 2 == 0) ? 128'h15 : 128'h0A;
            chk($sformatf("alt_top5_%0d", i), {123'd0, suffix[127:123]}, w);
        end

        // Consume while priming -> error with fill held, then slice start recovers.
        step(1'b0, 32'd0, 1'b0, 8'd0, 1'b1, "b_ss");
        step(1'b1, 32'h0F0F0F0F, 1'b0, 8'd0, 1'b0, "b_w0");
        step(1'b1, 32'hF0F0F0F0, 1'b0, 8'd0, 1'b0, "b_w1");
        step(1'b1, 32'h33333333, 1'b1, 8'd8, 1'b0, "b_err");
        chk("b_err_flags", {125'd0, in_ready, err, fill_level == 9'd64}, 128'd3);
        step(1'b1, 32'h44444444, 1'b0, 8'd0, 1'b0, "b_hold");
        step(1'b1, 32'h55555555, 1'b1, 8'd4, 1'b1, "b_clear");
        chk("b_clear_flags", {125'd0, in_ready, err, fill_level == 9'd0}, 128'd5);

        // Oversize consume at fill 200.
        for (int i = 0; i < 7; i++) step(1'b1, 32'h600D0000 + 32'(i), 1'b0, 8'd0, 1'b0, "c_fill");
        step(1'b0, 32'd0, 1'b1, 8'd24, 1'b0, "c_to200");
        chk("c_fill200", {119'd0, fill_level}, {119'd0, 9'd200});
        step(1'b0, 32'd0, 1'b1, 8'd129, 1'b0, "c_big");
        chk("c_big_err", {119'd0, err, fill_level}, {119'd0, 1'b1, 9'd200});
        step(1'b0, 32'd0, 1'b0, 8'd0, 1'b1, "c_ss");

        // Consume count 37 + 128 + 0, then reset mid-stream.
        for (int i = 0; i < 8; i++) step(1'b1, 32'hC0DE0000 + 32'(i), 1'b0, 8'd0, 1'b0, "e_fill");
        step(1'b0, 32'd0, 1'b1, 8'd37, 1'b0, "e_c37");
        step(1'b1, 32'h77777777, 1'b1, 8'd128, 1'b0, "e_c128");
        step(1'b1, 32'h88888888, 1'b0, 8'd0, 1'b0, "e_w");
        step(1'b0, 32'd0, 1'b1, 8'd0, 1'b0, "e_c0");
`ifdef DEC_SUFFIX_BITCNT_EN
        chk("e_cnt165", {96'd0, consumed_bits}, 128'd165);
`endif
        do_reset("midrst");
`ifdef DEC_SUFFIX_BITCNT_EN
        chk("midrst_cnt", {96'd0, consumed_bits}, 128'd0);
`endif
        step(1'b1, 32'hABCD1234, 1'b0, 8'd0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_ssm_suffix_window.md
Name: dec_ssm_suffix_window

Overview:
- Per-substream bit funnel that sits directly upstream of the BP-mode BPV/ECG parse block.
- Accepts 32-bit words from the substream FIFO and keeps them in a 256-bit buffer.
- Presents a 128-bit MSB-aligned suffix window to the parse stage, then left-shifts out the number of bits the parse stage reports as consumed (bp_size).

Parameters:
- ssm_idx, 0, substream index; carried for debug/ID only, no functional effect.
- WORD_W, 32, width of an input word from the substream FIFO.
- BUF_W, 256, internal buffer width; must be at least 128 + WORD_W and a multiple of WORD_W.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  reset; synchronous, active-low.
- slice_start  in  1  one-cycle pulse; synchronously discards all buffered bits.
- in_valid  in  1  input word valid from the substream FIFO.
- in_data  in  WORD_W  input word; bit WORD_W-1 is the first bit in the stream.
- in_ready  out  1  word accepted when in_valid && in_ready.
- suffix  out  128  window; suffix[127] is the next unconsumed bit.
- suffix_valid  out  1  window holds at least 128 valid bits.
- consume_valid  in  1  parse stage consumed bits this cycle.
- consume_size  in  8  bits consumed (bp_size), legal range 0..128.
- fill_level  out  9  number of valid bits in the buffer (0..BUF_W).
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: all outputs go to 0 while rst_n=0 at a clk edge: suffix, suffix_valid, in_ready, fill_level, err, and the buffer.
  - First cycle after reset: in_ready=1, because in_ready is derived from the registered fill.
- State machine (2-bit):
  - S_EMPTY: fill=0.
  - S_PRIME: 0 < fill < 128.
  - S_RUN: fill >= 128.
  - S_ERR: protocol violation seen.
  - The state is recomputed from fill_next every cycle, except S_ERR.
  - S_ERR is left only by reset or slice_start. In S_ERR, in_ready=0 and suffix_valid=0.
- in_ready = (fill <= BUF_W-WORD_W) && state != S_ERR. It is a function of registered state only, never of in_valid or consume_valid.
- suffix_valid = (state == S_RUN).
- suffix = buf[BUF_W-1 -: 128]. Bits below fill are zero.
- Per-cycle update, in this order:
  1. Consume: acc_c = consume_valid && suffix_valid. If acc_c, buf <<= consume_size and fill -= consume_size.
  2. Append: acc_w = in_valid && in_ready. If acc_w, in_data is written at buf[BUF_W-1-fill' -: WORD_W], where fill' is the fill after step 1. Then fill' += WORD_W.
- Simultaneous consume and append in one cycle is legal and required to work. Capacity cannot overflow, since in_ready guarantees at least WORD_W free bits before any consume.
- Latency:
  - A word accepted at edge N is visible in suffix/fill_level after edge N.
  - A consume at edge N gives the shifted window after edge N. This allows one parse per cycle.
- consume_size = 0 with consume_valid: legal no-op.
- Protocol errors (set err=1, enter S_ERR, ignore that cycle's consume and append):
  - consume_valid && !suffix_valid.
  - consume_size > 128.
- slice_start:
  - Priority: below reset, above everything else.
  - Clears buf, fill, and err; state goes to S_EMPTY.
  - Any same-cycle word or consume is dropped, and in_ready remains as registered.
- Reset mid-stream: identical to slice_start, plus in_ready cleared for that cycle.
- Arithmetic widths:
  - fill is 9 bits.
  - Shift amount is 8 bits.
  - Intermediate fill is computed 10 bits wide, then must lie in 0..BUF_W.

Optional Feature:
- Macro: DEC_SUFFIX_BITCNT_EN.
- Defined: adds output consumed_bits (out, 32), the total bits consumed since the last reset or slice_start.
  - It adds consume_size on every accepted consume and wraps modulo 2^32.
  - It is readable the cycle after each consume.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Shared package dec_pkg holds:
  - SUFFIX_W=128.
  - The state enum (S_EMPTY, S_PRIME, S_RUN, S_ERR).
  - MAX_CONSUME=128.
- One natural sub-module: dec_bit_shifter, a combinational BUF_W left barrel shifter with 8-bit shift amount. It is reusable by the other substream windows.

Test Plan:
- Reset, then 4 words 0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0xFFFF0000 → suffix_valid rises after the 4th acceptance; suffix = 0xDEADBEEF_01234567_89ABCDEF_FFFF0000; fill_level=128.
- Fill to 256 bits → in_ready=0. Consume 40 → fill=216 and in_ready=1 on the next cycle. A word accepted alongside consume 8 the following cycle gives fill=240.
- Sequence 1010…, consume_size=5 every cycle while streaming words each cycle → suffix[127:123] follows the stream exactly, with no gaps or repeats.
- consume_valid=1 with fill=64 → err=1, state S_ERR, fill unchanged at 64, in_ready=0. slice_start → err=0, fill=0, in_ready=1.
- consume_size=129 at fill=200 → err=1 and fill stays 200.
- With DEC_SUFFIX_BITCNT_EN: consumes of 37, 128, and 0 → consumed_bits=165. Reset mid-stream → consumed_bits=0 and all outputs 0.
